// File: rtl/fa_response_checker.sv
// fa_response_checker: watches the {a,b,c} stimulus applied to several
// full-adder implementations and their {y1,y0} responses. After each input
// change it waits for the inputs to settle, compares every implementation
// against the golden carry/sum, and records which of the 8 vectors have been
// covered. It reports pass/fail, a saturating mismatch count and a sticky
// error flag per implementation.
module fa_response_checker #(
    parameter int SETTLE = 4,   // stable cycles before sampling, 1..15
    parameter int NIMPL  = 3    // implementations checked in parallel
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic [2*NIMPL-1:0]   resp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           fail_cnt,
    output logic [7:0]           seen_mask,
    output logic [NIMPL-1:0]     err_impl,
    output logic                 mismatch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [2:0]         prev_reg;
    logic [2:0]         vec;
    logic               chg;
    logic               arm;
    logic [1:0]         golden;
    logic [NIMPL-1:0]   diff;
    logic [8:0]         n_diff;
    logic [8:0]         fail_sum;
    logic [7:0]         fail_sat;
    logic [7:0]         seen_upd;
    logic [7:0]         fail_cnt_reg;
    logic [7:0]         seen_mask_reg;
    logic [NIMPL-1:0]   err_impl_reg;
    logic               mismatch_reg;

    assign vec    = {a, b, c};
    assign chg    = (vec != prev_reg);
    // Golden response is simply the 2-bit arithmetic sum a+b+c.
    assign golden = 2'(a) + 2'(b) + 2'(c);

    // One comparator per implementation; !== makes X/Z count as wrong in sim.
    generate
        for (genvar gi = 0; gi < NIMPL; gi++) begin : g_cmp
            assign diff[gi] = (resp[2*gi +: 2] !== golden);
        end
    endgenerate

    // Count mismatching slices in this sample and saturate the running total.
    always_comb begin
        n_diff = '0;
        for (int i = 0; i < NIMPL; i++) begin
            n_diff = n_diff + {8'd0, diff[i]};
        end
        fail_sum = {1'b0, fail_cnt_reg} + n_diff;
        fail_sat = fail_sum[8] ? 8'hFF : fail_sum[7:0];
        seen_upd = seen_mask_reg | (8'd1 << vec);
    end

    // Previous-vector register; runs through reset so chg is clean afterwards.
    always_ff @(posedge clk) begin
        prev_reg <= vec;
    end

    // State and settle-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: settle, sample once, then hold until the vector moves.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        arm        = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_SETTLE;
                    cnt_next   = '0;
                    arm        = 1'b1;
                end
            end
            S_SETTLE: begin
                if (chg) begin
                    cnt_next = '0;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next = S_SAMPLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_SAMPLE: begin
                if (seen_upd == 8'hFF) begin
                    state_next = S_DONE;
                end else if (chg) begin
                    state_next = S_SETTLE;
                    cnt_next   = '0;
                end else begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (chg) begin
                    state_next = S_SETTLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
        // An early stop ends any run in progress; a sample in flight still lands.
        if (stop && (state_reg == S_SETTLE || state_reg == S_SAMPLE || state_reg == S_HOLD)) begin
            state_next = S_DONE;
        end
    end

    // Result registers: cleared on arm, updated only in the sample cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt_reg  <= '0;
            seen_mask_reg <= '0;
            err_impl_reg  <= '0;
            mismatch_reg  <= 1'b0;
        end else begin
            mismatch_reg <= 1'b0;
            if (arm) begin
                fail_cnt_reg  <= '0;
                seen_mask_reg <= '0;
                err_impl_reg  <= '0;
            end else if (state_reg == S_SAMPLE) begin
                mismatch_reg  <= |diff;
                fail_cnt_reg  <= fail_sat;
                err_impl_reg  <= err_impl_reg | diff;
                seen_mask_reg <= seen_upd;
            end
        end
    end

    assign busy      = (state_reg == S_SETTLE) || (state_reg == S_SAMPLE) || (state_reg == S_HOLD);
    assign done      = (state_reg == S_DONE);
    assign pass      = done && (fail_cnt_reg == 8'd0) && (seen_mask_reg == 8'hFF);
    assign fail_cnt  = fail_cnt_reg;
    assign seen_mask = seen_mask_reg;
    assign err_impl  = err_impl_reg;
    assign mismatch  = mismatch_reg;

endmodule

// File: tb/tb_fa_response_checker.sv
// Testbench for fa_response_checker: directed vectors, a cycle-indexed
// behavioural model compared on every clock, plus literal expectations.
module tb_fa_response_checker;

    localparam int SETTLE = 4;
    localparam int NIMPL  = 3;

    logic               clk = 1'b0;
    logic               rst_n, start, stop, a, b, c;
    logic [2*NIMPL-1:0] resp;
    logic               busy, done, pass, mismatch;
    logic [7:0]         fail_cnt, seen_mask;
    logic [NIMPL-1:0]   err_impl;

    int total = 0;
    int bad   = 0;
    int n_mis_seen = 0;

    fa_response_checker #(.SETTLE(SETTLE), .NIMPL(NIMPL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .a(a), .b(b), .c(c), .resp(resp),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .seen_mask(seen_mask), .err_impl(err_impl), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // Every implementation correct: each slice is the sum a+b+c.
    function automatic logic [5:0] good(input logic [2:0] v);
        logic [1:0] s;
        s = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
        return {s, s, s};
    endfunction

    // Every implementation wrong: each slice is the inverted sum.
    function automatic logic [5:0] wrong(input logic [2:0] v);
        logic [1:0] s;
        s = ~(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
        return {s, s, s};
    endfunction

    // ---------------- behavioural model ----------------
    // A run samples the vector SETTLE+1 edges after the later of the arming
    // edge and the last input change, provided that point lies after the
    // previous sample (a held vector is sampled only once).
    int         edge_n = 0;
    bit         m_run = 0, m_done = 0, m_mis = 0;
    int         m_fail = 0;
    logic [7:0] m_seen = 0;
    logic [2:0] m_err = 0;
    int         arm_edge = 0, last_chg = 0, last_smp = -1;
    logic [2:0] m_prev = 0;

    always @(posedge clk) begin
        logic [2:0] v;
        logic [1:0] gold;
        int         ref_e;
        int         nbad;
        v = {a, b, c};
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_mis = 0;
            m_fail = 0; m_seen = 0; m_err = 0;
        end else begin
            m_mis = 0;
            if (m_run) begin
                ref_e = (arm_edge > last_chg) ? arm_edge : last_chg;
                if (ref_e >= last_smp && edge_n - ref_e == SETTLE + 1) begin
                    gold = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
                    nbad = 0;
                    for (int i = 0; i < NIMPL; i++) begin
                        if (resp[2*i +: 2] !== gold) begin
                            nbad++;
                            m_err[i] = 1'b1;
                        end
                    end
                    m_fail   = (m_fail + nbad > 255) ? 255 : m_fail + nbad;
                    m_seen[v] = 1'b1;
                    m_mis    = (nbad > 0);
                    last_smp = edge_n;
                    if (m_seen == 8'hFF) begin
                        m_run = 0; m_done = 1;
                    end
                end
                if (m_run && stop) begin
                    m_run = 0; m_done = 1;
                end
                if (v != m_prev) last_chg = edge_n;
            end else if (start) begin
                m_run = 1; m_done = 0;
                arm_edge = edge_n; last_chg = edge_n; last_smp = -1;
                m_fail = 0; m_seen = 0; m_err = 0;
            end
        end
        m_prev = v;
        edge_n++;
        #1;
        if (mismatch === 1'b1) n_mis_seen++;
        check("busy",      32'(busy),      32'(m_run));
        check("done",      32'(done),      32'(m_done));
        check("pass",      32'(pass),      32'(m_done && m_fail == 0 && m_seen == 8'hFF));
        check("fail_cnt",  32'(fail_cnt),  32'(m_fail));
        check("seen_mask", 32'(seen_mask), 32'(m_seen));
        check("err_impl",  32'(err_impl),  32'(m_err));
        check("mismatch",  32'(mismatch),  32'(m_mis));
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [2:0] v, input logic [5:0] r, input int cycles);
        @(negedge clk);
        {a, b, c} = v;
        resp = r;
        $display("apply vec=%b resp=%b hold=%0d", v, r, cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    initial begin
        int mis0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        {a, b, c} = 3'b000; resp = good(3'b000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_seen", 32'(seen_mask), 0);
        check("rst_fail", 32'(fail_cnt), 0);
        @(negedge clk) rst_n = 1'b1;

        // All eight vectors, every implementation correct.
        mis0 = n_mis_seen;
        pulse_start();
        for (int v = 0; v < 8; v++) apply(3'(v), good(3'(v)), 10);
        check("t1_done", 32'(done), 1);
        check("t1_pass", 32'(pass), 1);
        check("t1_seen", 32'(seen_mask), 32'hFF);
        check("t1_fail", 32'(fail_cnt), 0);
        check("t1_err",  32'(err_impl), 0);
        check("t1_nmis", 32'(n_mis_seen - mis0), 0);

        // Implementation 1 wrong on vector 111 only.
        pulse_start();
        for (int v = 0; v < 7; v++) apply(3'(v), good(3'(v)), 10);
        @(negedge clk);
        {a, b, c} = 3'b111; resp = 6'b11_00_11;
        $display("apply vec=111 resp=110011 impl1 faulty");
        repeat (5) @(posedge clk);
        #1 check("t2_early_mis", 32'(mismatch), 0);
        @(posedge clk);
        #1 check("t2_lat_mis", 32'(mismatch), 1);
        check("t2_done_now", 32'(done), 1);
        repeat (2) @(posedge clk);
        #1;
        check("t2_fail", 32'(fail_cnt), 1);
        check("t2_err",  32'(err_impl), 32'b010);
        check("t2_pass", 32'(pass), 0);

        // Glitching input: a toggles every 3 cycles, then holds at 111.
        pulse_start();
        apply(3'b011, good(3'b011), 3);
        apply(3'b111, good(3'b111), 3);
        apply(3'b011, good(3'b011), 3);
        @(negedge clk);
        {a, b, c} = 3'b111; resp = good(3'b111);
        $display("apply vec=111 resp=%b final hold", good(3'b111));
        repeat (5) @(posedge clk);
        #1 check("t3_no_early", 32'(seen_mask), 0);
        @(posedge clk);
        #1 check("t3_seen", 32'(seen_mask), 32'h80);
        check("t3_fail", 32'(fail_cnt), 0);
        pulse_stop();
        check("t3_stop_done", 32'(done), 1);
        check("t3_stop_pass", 32'(pass), 0);

        // Early stop after five distinct vectors.
        pulse_start();
        for (int v = 0; v < 5; v++) apply(3'(v), good(3'(v)), 8);
        @(negedge clk) stop = 1'b1;
        @(posedge clk);
        #1;
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_seen", 32'(seen_mask), 32'h1F);
        check("t4_fail", 32'(fail_cnt), 0);
        check("t4_pass", 32'(pass), 0);
        @(negedge clk) stop = 1'b0;

        // Saturation: seven vectors, all implementations wrong, 13 rounds.
        pulse_start();
        for (int r = 0; r < 13; r++) begin
            for (int v = 0; v < 7; v++) apply(3'(v), wrong(3'(v)), 6);
            if (r == 0) check("t5_round1", 32'(fail_cnt), 21);
        end
        check("t5_sat",  32'(fail_cnt), 255);
        check("t5_err",  32'(err_impl), 32'b111);
        check("t5_busy", 32'(busy), 1);
        apply(3'b111, wrong(3'b111), 8);
        check("t5_done", 32'(done), 1);
        check("t5_sat2", 32'(fail_cnt), 255);
        check("t5_pass", 32'(pass), 0);
        pulse_start();
        check("t5_rearm_fail", 32'(fail_cnt), 0);
        check("t5_rearm_seen", 32'(seen_mask), 0);

        // Reset in the middle of a settle window with seen_mask = 0F.
        for (int v = 0; v < 4; v++) apply(3'(v), good(3'(v)), 6);
        @(negedge clk);
        {a, b, c} = 3'b100; resp = good(3'b100);
        repeat (2) @(posedge clk);
        #1;
        check("t6_pre_seen", 32'(seen_mask), 32'h0F);
        check("t6_pre_busy", 32'(busy), 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 0);
        check("t6_done", 32'(done), 0);
        check("t6_pass", 32'(pass), 0);
        check("t6_fail", 32'(fail_cnt), 0);
        check("t6_seen", 32'(seen_mask), 0);
        check("t6_err",  32'(err_impl), 0);
        check("t6_mis",  32'(mismatch), 0);
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        check("t6_restart_seen", 32'(seen_mask), 0);
        check("t6_restart_busy", 32'(busy), 1);
        apply(3'b101, good(3'b101), 8);
        check("t6_after_seen", 32'(seen_mask), 32'h20);

        repeat (2) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
